// File: rtl/alu4_nibble_seq_if.sv
// alu4_nibble_seq_if
//   Bundles the host-side request/response bus and the shared 4-bit ALU bus
//   of the nibble sequencer.
//
//   Handshake: the host raises start with op/a/b/carry_in/rot_in stable.
//   The request is taken on any clock edge where the sequencer is idle
//   (busy=0). start is ignored while busy=1 and is not queued. done pulses
//   for exactly one cycle when result and flags are valid. abort cancels a
//   running operation without a done pulse.
//
//   Modports:
//     slave  - the sequencer (takes requests, drives the ALU operands)
//     master - the host plus ALU environment around the sequencer
interface alu4_nibble_seq_if #(
  parameter int WIDTH = 16
);
  // host request
  logic             start;
  logic             abort;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             rot_in;
  // host response
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             rot_out;
  logic             ovf;
  logic             zero;
  // ALU drive
  logic [3:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             alu_mci;
  logic             alu_rci;
  // ALU return
  logic [3:0]       alu_res;
  logic             alu_mco;
  logic             alu_rco;
  logic             alu_ovf;
  logic             alu_zero;
  // FSM state, for observation only
  logic [1:0]       state_dbg;

  modport slave (
    input  start, abort, op, a, b, carry_in, rot_in,
    input  alu_res, alu_mco, alu_rco, alu_ovf, alu_zero,
    output busy, done, result, carry_out, rot_out, ovf, zero,
    output alu_op, alu_a, alu_b, alu_mci, alu_rci,
    output state_dbg
  );

  modport master (
    output start, abort, op, a, b, carry_in, rot_in,
    output alu_res, alu_mco, alu_rco, alu_ovf, alu_zero,
    input  busy, done, result, carry_out, rot_out, ovf, zero,
    input  alu_op, alu_a, alu_b, alu_mci, alu_rci,
    input  state_dbg
  );
endinterface

// File: rtl/alu4_nibble_seq.sv
// alu4_nibble_seq
//   Multi-precision sequencer for a shared combinational 4-bit ALU. One
//   WIDTH-bit operation is latched from the host, then the ALU is driven one
//   nibble per clock while math and rotate carries are chained between
//   nibbles. Result nibbles are collected, and final carry/rotate/overflow/
//   zero flags are reported together with a one-cycle done pulse.
//
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset
//     bus    - alu4_nibble_seq_if.slave: host request/response and ALU bus
//              (state_dbg exposes the FSM state: 0 IDLE, 1 RUN, 2 DONE)
//
//   Latency: start taken at edge 0, done high in the cycle after edge NIB,
//   busy high from edge 0 until edge NIB+1.
module alu4_nibble_seq #(
  parameter int          WIDTH       = 16,
  parameter logic [15:0] RSHIFT_MASK = 16'hA800
) (
  input logic               clk,
  input logic               rst_n,
  alu4_nibble_seq_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dir_q, dir_d;     // 1: MSB nibble first
  logic             mc_q, mc_d;       // chained math carry
  logic             rc_q, rc_d;       // chained rotate carry
  logic             zacc_q, zacc_d;   // AND of per-nibble zero flags so far
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             rot_out_q, rot_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CW-1:0]    idx;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;

  // Nibble currently on the ALU: cnt walks up from 0, mirrored for MSB-first.
  always_comb begin
    idx   = dir_q ? (LAST - cnt_q) : cnt_q;
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (idx == CW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dir_d       = dir_q;
    mc_d        = mc_q;
    rc_d        = rc_q;
    zacc_d      = zacc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    rot_out_d   = rot_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort has no meaning here
        if (bus.start) begin
          state_d = S_RUN;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          mc_d    = bus.carry_in;
          rc_d    = bus.rot_in;
          dir_d   = RSHIFT_MASK[bus.op];
          cnt_d   = '0;
          zacc_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          // partial result nibbles and previous flags are left untouched
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          for (int n = 0; n < NIB; n++) begin
            if (idx == CW'(n)) begin
              result_d[4*n +: 4] = bus.alu_res;
            end
          end
          mc_d   = bus.alu_mco;
          rc_d   = bus.alu_rco;
          zacc_d = zacc_q & bus.alu_zero;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            carry_out_d = bus.alu_mco;
            rot_out_d   = bus.alu_rco;
            ovf_d       = bus.alu_ovf;
            zero_d      = zacc_q & bus.alu_zero;
            cnt_d       = '0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 4'h0;
      a_q         <= '0;
      b_q         <= '0;
      dir_q       <= 1'b0;
      mc_q        <= 1'b0;
      rc_q        <= 1'b0;
      zacc_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      rot_out_q   <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dir_q       <= dir_d;
      mc_q        <= mc_d;
      rc_q        <= rc_d;
      zacc_q      <= zacc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      rot_out_q   <= rot_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // The shared ALU sees zeros whenever this sequencer is not running.
  assign bus.alu_op    = (state_q == S_RUN) ? op_q  : 4'h0;
  assign bus.alu_a     = (state_q == S_RUN) ? a_nib : 4'h0;
  assign bus.alu_b     = (state_q == S_RUN) ? b_nib : 4'h0;
  assign bus.alu_mci   = (state_q == S_RUN) & mc_q;
  assign bus.alu_rci   = (state_q == S_RUN) & rc_q;

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.rot_out   = rot_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_alu4_nibble_seq.sv
// tb_alu4_nibble_seq
//   Bench for alu4_nibble_seq at WIDTH=16. A 4-bit ALU is modelled here so
//   the sequencer has something to drive; results are predicted by a
//   whole-width reference model of the same opcode set.
//   ALU opcodes: 4 add, 5 subtract (a + ~b + c), E rotate left through
//   carry, F rotate right through carry; all others bitwise on op[1:0]
//   (and, or, xor, not a) with carries passed through.
module tb_alu4_nibble_seq;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu4_nibble_seq_if #(.WIDTH(W)) bus ();

  alu4_nibble_seq #(.WIDTH(W), .RSHIFT_MASK(16'hA800)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- 4-bit ALU ----------------
  logic [3:0] alu_r;
  logic       alu_mc, alu_rc, alu_v;
  logic [4:0] alu_t;

  always_comb begin
    alu_t  = 5'd0;
    alu_r  = 4'h0;
    alu_mc = bus.alu_mci;
    alu_rc = bus.alu_rci;
    alu_v  = 1'b0;
    case (bus.alu_op)
      4'h4: begin
        alu_t  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_mci};
        alu_r  = alu_t[3:0];
        alu_mc = alu_t[4];
        alu_v  = (bus.alu_a[3] == bus.alu_b[3]) && (alu_t[3] != bus.alu_a[3]);
      end
      4'h5: begin
        alu_t  = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {4'd0, bus.alu_mci};
        alu_r  = alu_t[3:0];
        alu_mc = alu_t[4];
        alu_v  = (bus.alu_a[3] != bus.alu_b[3]) && (alu_t[3] != bus.alu_a[3]);
      end
      4'hE: begin
        alu_r  = {bus.alu_a[2:0], bus.alu_rci};
        alu_rc = bus.alu_a[3];
      end
      4'hF: begin
        alu_r  = {bus.alu_rci, bus.alu_a[3:1]};
        alu_rc = bus.alu_a[0];
      end
      default: begin
        case (bus.alu_op[1:0])
          2'd0:    alu_r = bus.alu_a & bus.alu_b;
          2'd1:    alu_r = bus.alu_a | bus.alu_b;
          2'd2:    alu_r = bus.alu_a ^ bus.alu_b;
          default: alu_r = ~bus.alu_a;
        endcase
      end
    endcase
  end

  assign bus.alu_res  = alu_r;
  assign bus.alu_mco  = alu_mc;
  assign bus.alu_rco  = alu_rc;
  assign bus.alu_ovf  = alu_v;
  assign bus.alu_zero = (alu_r == 4'h0);

  // ---------------- whole-width reference model ----------------
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, b,
                                    input logic ci, ri, output logic [W-1:0] res,
                                    output logic co, ro, ov, z);
    logic [W:0] t;
    t   = '0;
    res = '0;
    co  = ci;
    ro  = ri;
    ov  = 1'b0;
    case (op)
      4'h4: begin
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        res = t[W-1:0];
        co  = t[W];
        ov  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      4'h5: begin
        t   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ci};
        res = t[W-1:0];
        co  = t[W];
        ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      4'hE: begin
        res = {a[W-2:0], ri};
        ro  = a[W-1];
      end
      4'hF: begin
        res = {ri, a[W-1:1]};
        ro  = a[0];
      end
      default: begin
        case (op[1:0])
          2'd0:    res = a & b;
          2'd1:    res = a | b;
          2'd2:    res = a ^ b;
          default: res = ~a;
        endcase
      end
    endcase
    z = (res == '0);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  // last completed flags, which must survive aborts
  logic m_co = 1'b0, m_ro = 1'b0, m_ov = 1'b0, m_z = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_done"},   32'(bus.done), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_flags"},  32'({bus.carry_out, bus.rot_out, bus.ovf, bus.zero}), 32'd0);
    chk({tag, "_alu"},    32'({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mci, bus.alu_rci}), 32'd0);
  endtask

  // ---------------- driver ----------------
  // abort_at: 0 = none, k = abort sampled at RUN edge k (1..NIB).
  // hammer: start re-asserted with garbage operands through the whole run.
  // abort_w_start: abort raised together with start (start must win).
  task automatic run_op(input logic [3:0] op_i, input logic [W-1:0] a_i, b_i,
                        input logic ci, ri, input int abort_at, input bit hammer,
                        input bit abort_w_start);
    logic [W-1:0] e_res;
    logic         e_co, e_ro, e_ov, e_z, msb_first;
    int           done_k, done_n;
    ref_model(op_i, a_i, b_i, ci, ri, e_res, e_co, e_ro, e_ov, e_z);
    msb_first = (op_i == 4'hB) || (op_i == 4'hD) || (op_i == 4'hF);
    if (abort_at == 0) exp_q.push_back(e_res);

    @(negedge clk);
    bus.op = op_i; bus.a = a_i; bus.b = b_i;
    bus.carry_in = ci; bus.rot_in = ri;
    bus.start = 1'b1; bus.abort = abort_w_start;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = hammer;
    if (hammer) begin
      bus.op = 4'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
      bus.carry_in = 1'($urandom); bus.rot_in = 1'($urandom);
    end

    // first RUN cycle: ALU sees the latched op and the first nibble
    @(negedge clk);
    chk("busy_run", 32'(bus.busy), 32'd1);
    chk("alu_op", 32'(bus.alu_op), 32'(op_i));
    chk("alu_a0", 32'(bus.alu_a), msb_first ? 32'(a_i[W-1:W-4]) : 32'(a_i[3:0]));
    chk("alu_b0", 32'(bus.alu_b), msb_first ? 32'(b_i[W-1:W-4]) : 32'(b_i[3:0]));
    chk("alu_cin", 32'({bus.alu_mci, bus.alu_rci}), 32'({ci, ri}));

    done_k = 0;
    done_n = 0;
    for (int k = 1; k <= NIB + 3; k++) begin
      if (k == abort_at) bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      bus.start = hammer && (abort_at == 0) && (k + 1 <= NIB);
      @(negedge clk);
      if (bus.done) begin
        done_n++;
        if (done_k == 0) done_k = k;
        if (exp_q.size() > 0) chk("result_sb", 32'(bus.result), 32'(exp_q.pop_front()));
      end
      if (abort_at == 0 && k == NIB)     chk("busy_in_done", 32'(bus.busy), 32'd1);
      if (abort_at == 0 && k == NIB + 1) chk("busy_after", 32'(bus.busy), 32'd0);
      if (k == abort_at)                 chk("busy_after_abort", 32'(bus.busy), 32'd0);
    end

    if (abort_at == 0) begin
      chk("done_cycle", 32'(done_k), 32'(NIB));
      chk("done_count", 32'(done_n), 32'd1);
      chk("result", 32'(bus.result), 32'(e_res));
      chk("carry_out", 32'(bus.carry_out), 32'(e_co));
      chk("rot_out", 32'(bus.rot_out), 32'(e_ro));
      chk("ovf", 32'(bus.ovf), 32'(e_ov));
      chk("zero", 32'(bus.zero), 32'(e_z));
      m_co = e_co; m_ro = e_ro; m_ov = e_ov; m_z = e_z;
    end else begin
      chk("abort_done_count", 32'(done_n), 32'd0);
      chk("abort_flags", 32'({bus.carry_out, bus.rot_out, bus.ovf, bus.zero}),
          32'({m_co, m_ro, m_ov, m_z}));
    end
    chk("alu_idle", 32'({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mci, bus.alu_rci}), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int abort_at;
    bit hammer;
    bus.start = 1'b0; bus.abort = 1'b0; bus.op = 4'h0;
    bus.a = '0; bus.b = '0; bus.carry_in = 1'b0; bus.rot_in = 1'b0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // directed cases
    run_op(4'h4, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'h4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'h5, 16'h1234, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'h5, 16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'hF, 16'h0001, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_op(4'hE, 16'h8000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'h4, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_op(4'h4, 16'h3333, 16'h4444, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_op(4'h2, 16'hA5A5, 16'h0FF0, 1'b1, 1'b1, 0, 1'b0, 1'b1);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    bus.op = 4'h4; bus.a = 16'h1234; bus.b = 16'h1111;
    bus.carry_in = 1'b0; bus.rot_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m_co = 1'b0; m_ro = 1'b0; m_ov = 1'b0; m_z = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h4, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NIB)) : 0;
      hammer   = (abort_at == 0) && ($urandom_range(0, 3) == 0);
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
             1'($urandom), 1'($urandom), abort_at, hammer, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu4_nibble_seq.md
Name: alu4_nibble_seq

Overview:
- Multi-precision sequencer for the combinational 4-bit ALU datapath.
- Accepts one WIDTH-bit operation from a host and drives the ALU one nibble per clock.
- Chains math carry and rotate carry between nibbles, collects result nibbles, and reports final carry, rotate, overflow and zero flags with a done pulse.
- Sits between a host/register file and a single shared ALU instance.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, >= 4; NIB = WIDTH/4
RSHIFT_MASK, 16'hA800, bit k set => opcode k is processed MSB nibble first (right shifts/rotates 4'hB, 4'hD, 4'hF); all others LSB first

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel of a running operation
op  in  4  ALU opcode for the whole operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
carry_in  in  1  math carry into first nibble
rot_in  in  1  rotate carry into first nibble
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
result  out  WIDTH  assembled result
carry_out  out  1  final ALU math carry
rot_out  out  1  final ALU rotate carry
ovf  out  1  overflow from last nibble processed
zero  out  1  1 iff every result nibble is zero
alu_op  out  4  to ALU opcode
alu_a  out  4  to ALU A nibble
alu_b  out  4  to ALU B nibble
alu_mci  out  1  to ALU math carry in
alu_rci  out  1  to ALU rotate carry in
alu_res  in  4  from ALU sum
alu_mco  in  1  from ALU math carry out
alu_rco  in  1  from ALU rotate carry out
alu_ovf  in  1  from ALU overflow
alu_zero  in  1  from ALU zero

Behaviour:
- Reset (async, rst_n=0): state IDLE, cnt=0, all latched operands/carries 0.
- Reset outputs: busy=0, done=0, result=0, carry_out=0, rot_out=0, ovf=0, zero=0, alu_* = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a clock edge with start=1.
  - Latch op, a, b, carry_in, rot_in.
  - Set dir = RSHIFT_MASK[op] and cnt=0.
  - Preset the zero accumulator to 1.
- RUN, nibble index: idx = cnt when dir=0; NIB-1-cnt when dir=1.
- RUN, ALU drive (combinational from registers):
  - alu_op = latched op.
  - alu_a = a[4*idx+3:4*idx]; alu_b likewise from b.
  - alu_mci/alu_rci = the latched chain carries.
- RUN, each edge:
  - result[4*idx+3:4*idx] <= alu_res.
  - Chain math carry <= alu_mco; chain rotate carry <= alu_rco.
  - zacc <= zacc & alu_zero.
  - cnt++.
  - At cnt = NIB-1: also carry_out <= alu_mco, rot_out <= alu_rco, ovf <= alu_ovf, zero <= zacc & alu_zero; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge NIB; busy high from edge 0 until edge NIB+1.
- start while busy (RUN or DONE): ignored, not queued. Host must see busy=0 before the next start.
- abort=1 in RUN: go to IDLE at that edge, no done pulse.
  - result holds partially written nibbles.
  - Flag outputs keep their previous values.
- abort in IDLE or DONE: no effect; DONE still pulses.
- abort and start high together in IDLE: start wins.
- Outside RUN: alu_op/alu_a/alu_b/alu_mci/alu_rci = 0.
- Outputs hold until overwritten by the next operation.
- WIDTH=4: single RUN cycle; behaviour identical to a direct ALU access plus two cycles latency.
- Opcode-agnostic: the ALU alone defines each opcode's per-nibble semantics. The controller only orders nibbles and chains carries.

Test Plan:
- WIDTH=16, op=4'h4 (add), a=16'h0FFF, b=16'h0001, carry_in=0 -> result=16'h1000, carry_out=0, zero=0, ovf=0. done one cycle, exactly 4 cycles after the start edge; busy low the cycle after.
- op=4'h4, a=16'hFFFF, b=16'h0001, carry_in=0 -> result=16'h0000, carry_out=1, zero=1.
- op=4'h5 (subtract), a=16'h1234, b=16'h1234, carry_in=1 -> result=0, carry_out=1, zero=1. Repeat with a=16'h7FFF, b=16'hFFFF -> result=16'h8000, ovf=1.
- op=4'hF (rotate right through carry, MSB first), a=16'h0001, rot_in=1 -> result=16'h8000, rot_out=1, zero=0. op=4'hE (rotate left, LSB first), a=16'h8000, rot_in=0 -> result=0, rot_out=1.
- start pulsed again at cycles 1-4 of a running add -> ignored, single done, result unchanged. abort at RUN cycle 2 -> no done, busy=0 next cycle, flags unchanged.
- rst_n low asynchronously mid-RUN -> all outputs 0 immediately. After release, a new start completes normally.
